// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO-to-stream reader: FSM encoding and output
// buffer sizing.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);
  localparam int PTR_WIDTH = $clog2(BUF_DEPTH);

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry output buffer between the FIFO read port and the stream interface.
// The writer must only write when an entry is free (guaranteed by the credit logic).
module stream_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  valid_o,
  output logic [OCC_WIDTH-1:0]  occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q;
  logic [PTR_WIDTH-1:0]  rd_ptr_q;
  logic [OCC_WIDTH-1:0]  occ_q;
  logic [OCC_WIDTH-1:0]  occ_d;
  logic                  do_rd;

  assign do_rd     = rd_en_i && (occ_q != '0);
  assign valid_o   = (occ_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign occ_o     = occ_q;

  always_comb begin
    occ_d = occ_q;
    unique case ({wr_en_i, do_rd})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: storage is reset only because the head entry drives m_tdata,
      // which must read zero out of reset; plain data RAMs normally skip this.
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops cmd_len words from a registered-output FIFO and streams them out with
// valid/ready handshaking, tagging the final word with m_tlast.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_start,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_r_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] len_m1;
  logic                 inflight_q;
  logic                 zero_done_q, zero_done_d;
  logic [OCC_WIDTH-1:0] occ;
  logic [2:0]           pending;
  logic                 accept;
  logic                 has_credit;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (inflight_q),
    .wr_data_i (fifo_data),
    .rd_en_i   (m_tready),
    .rd_data_o (m_tdata),
    .valid_o   (m_tvalid),
    .occ_o     (occ)
  );

  assign accept = m_tvalid && m_tready;

  // The beat leaving this cycle frees its slot at the same edge a new pop
  // would land, so counting it keeps one word per cycle with no overflow.
  assign pending    = 3'(occ) + 3'(inflight_q) - 3'(accept);
  assign has_credit = (pending < 3'(BUF_DEPTH));

  assign fifo_r_en = (state_q == ST_RUN) && (rem_q != '0) && has_credit && !fifo_empty;
  assign len_m1    = len_q - 1'b1;
  assign m_tlast   = m_tvalid && (beat_cnt_q == len_m1);
  assign busy      = (state_q != ST_IDLE);
  assign done      = zero_done_q || ((state_q == ST_DRAIN) && accept && m_tlast);

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path can leave
    // one unassigned and infer a latch.
    state_d     = state_q;
    rem_d       = rem_q;
    beat_cnt_d  = beat_cnt_q;
    len_d       = len_q;
    zero_done_d = 1'b0;

    if (fifo_r_en) rem_d = rem_q - 1'b1;
    if (accept)    beat_cnt_d = beat_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          if (cmd_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            rem_d      = cmd_len;
            len_d      = cmd_len;
            beat_cnt_d = '0;
          end
        end
      end
      ST_RUN: begin
        if (rem_d == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accept && m_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      beat_cnt_q  <= beat_cnt_d;
      len_q       <= len_d;
      inflight_q  <= fifo_r_en;
      zero_done_q <= zero_done_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural registered-read FIFO, in-order
// stream scoreboard, a cycle table for the nominal transfer, directed corners and random transfers.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_start = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          busy, done, fifo_r_en;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b0;

  logic          push_req = 1'b0;
  logic [DW-1:0] push_val = '0;
  logic [DW-1:0] fifo_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] sb_q[$];
  logic          model_busy = 1'b0;
  logic          zero_pending = 1'b0;
  logic          rst_chk = 1'b0;
  logic          stall_v = 1'b0;
  logic [DW-1:0] stall_d = '0;
  logic          stall_l = 1'b0;
  int            cur_len = 0;
  int            beat_idx = 0;
  int            pops = 0;

  typedef struct {
    logic          start;
    int            len;
    logic          rdy;
    logic          busy;
    logic          ren;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          done;
  } vec_t;

  vec_t tbl[8];

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_start  (cmd_start),
    .cmd_len    (cmd_len),
    .busy       (busy),
    .done       (done),
    .fifo_r_en  (fifo_r_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast)
  );

  always #5 clk = ~clk;

  // FIFO with registered read data; garbage on fifo_data whenever no pop happened.
  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_q.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_r_en && !fifo_empty) fifo_data <= fifo_q.pop_front();
      else                          fifo_data <= DW'($urandom);
      if (push_req) fifo_q.push_back(push_val);
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, update the model.
  task automatic step(input logic rst, input logic start, input int len, input logic rdy,
                      input logic push, input logic [DW-1:0] pval);
    logic was_busy, beat, exp_last;
    @(negedge clk);
    rst_n     = rst;
    cmd_start = start;
    cmd_len   = LW'(len);
    m_tready  = rdy;
    push_req  = push;
    push_val  = pval;
    #1;
    if (rst_chk) begin
      check("rst_busy",   32'(busy),      0);
      check("rst_done",   32'(done),      0);
      check("rst_r_en",   32'(fifo_r_en), 0);
      check("rst_tvalid", 32'(m_tvalid),  0);
      check("rst_tlast",  32'(m_tlast),   0);
      check("rst_tdata",  32'(m_tdata),   0);
      rst_chk = 1'b0;
    end
    if (!rst) begin
      sb_q.delete();
      model_busy   = 1'b0;
      zero_pending = 1'b0;
      stall_v      = 1'b0;
      rst_chk      = 1'b1;
      return;
    end

    was_busy = model_busy;
    beat     = m_tvalid && m_tready;
    check("busy", 32'(busy), 32'(model_busy));
    if (!was_busy) check("idle_tvalid", 32'(m_tvalid), 0);
    if (zero_pending) begin
      check("done_len0", 32'(done), 1);
      zero_pending = 1'b0;
    end else if (!beat) begin
      check("done_quiet", 32'(done), 0);
    end
    if (stall_v) begin
      check("stall_tvalid", 32'(m_tvalid), 1);
      check("stall_tdata",  32'(m_tdata),  32'(stall_d));
      check("stall_tlast",  32'(m_tlast),  32'(stall_l));
    end
    if (fifo_r_en) begin
      check("pop_nonempty",  32'(fifo_empty), 0);
      check("pop_in_budget", 32'(model_busy && (pops < cur_len)), 1);
      pops++;
    end
    if (beat) begin
      if (!model_busy || sb_q.size() == 0) begin
        check("beat_unexpected", 32'(beat), 0);
      end else begin
        exp_last = (beat_idx == cur_len - 1);
        check("tdata",        32'(m_tdata), 32'(sb_q[0]));
        check("tlast",        32'(m_tlast), 32'(exp_last));
        check("done_on_last", 32'(done),    32'(exp_last));
        void'(sb_q.pop_front());
        beat_idx++;
        if (exp_last) begin
          check("pop_total", 32'(pops), 32'(cur_len));
          model_busy = 1'b0;
        end
      end
    end
    stall_v = m_tvalid && !m_tready;
    stall_d = m_tdata;
    stall_l = m_tlast;
    if (push) sb_q.push_back(pval);
    if (start && !was_busy) begin
      if (len == 0) zero_pending = 1'b1;
      else begin
        model_busy = 1'b1;
        cur_len    = len;
        beat_idx   = 0;
        pops       = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    idle(1);
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b1, 1'b1, base + DW'(i));
  endtask

  // rdy_mode < 0: ready pattern 1,0,0 repeating; otherwise percent chance of ready.
  task automatic run_xfer(input int len, input int rdy_mode, input int push_every,
                          input int restart_at, input int reset_after);
    int   cyc;
    int   budget;
    logic st, rdy, push;
    int   ln;
    cyc    = 0;
    budget = 40 + len * 12;
    do begin
      if (reset_after >= 0 && model_busy && beat_idx >= reset_after) begin
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
        break;
      end
      st   = (cyc == 0) || (cyc == restart_at);
      ln   = (cyc == 0) ? len : 2;
      rdy  = (rdy_mode < 0) ? (cyc % 3 == 0) : ($urandom_range(99) < rdy_mode);
      push = (push_every > 0) && (cyc % push_every == 0);
      step(1'b1, st, ln, rdy, push, DW'($urandom));
      cyc++;
    end while ((model_busy || zero_pending) && cyc < budget);
    if (model_busy) begin
      check("xfer_timeout_beats", 32'(beat_idx), 32'(cur_len));
      do_reset();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    do_reset();

    // Nominal 4-word transfer at full rate, checked cycle by cycle.
    preload(4, 8'h11);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].start, tbl[i].len, tbl[i].rdy, 1'b0, '0);
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_r_en", i), 32'(fifo_r_en), 32'(tbl[i].ren));
      check($sformatf("tbl%0d_tvalid", i), 32'(m_tvalid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_tlast", i), 32'(m_tlast), 32'(tbl[i].last));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      if (tbl[i].valid) check($sformatf("tbl%0d_tdata", i), 32'(m_tdata), 32'(tbl[i].data));
    end

    // Back-pressure 1,0,0 with more words available than requested.
    preload(5, 8'h21);
    run_xfer(3, -1, 0, -1, -1);
    idle(2);
    check("fifo_left_after_len3", 32'(fifo_q.size()), 2);

    // Starved FIFO: one word every third cycle.
    do_reset();
    run_xfer(2, 100, 3, -1, -1);
    idle(2);

    // Zero-length command.
    run_xfer(0, 100, 0, -1, -1);
    idle(2);

    // cmd_start while busy must not alter the running count.
    run_xfer(5, 100, 1, 3, -1);
    idle(2);

    // Reset after two of five beats, then a fresh single-word transfer.
    run_xfer(5, 100, 1, -1, 2);
    idle(1);
    run_xfer(1, 100, 1, -1, -1);
    idle(2);

    // Random transfers against the scoreboard.
    for (int t = 0; t < 25; t++) begin
      int l;
      l = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1));
      run_xfer(l, int'($urandom_range(100, 40)), int'($urandom_range(3, 1)), -1, -1);
      idle(int'($urandom_range(3)));
    end

    // Maximum length: no counter wrap-around.
    run_xfer((1 << LW) - 1, 100, 1, -1, -1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
